// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - width limits and maximal-length XNOR tap masks shared by lfsr
package lfsr_pkg;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  // Bit i of the mask is set when 1-based tap position i+1 feeds the XNOR.
  function automatic logic [31:0] lfsr_tap_mask(input int num_bits);
    logic [31:0] mask;
    mask = '0;
    case (num_bits)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - Fibonacci XNOR LFSR with seed load and seed-match Done flag
// Optional LFSR_LOCKUP_GUARD_EN: a shift out of the all-ones lockup state goes to all-zeros.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
    $error("lfsr: NUM_BITS must be within 3..32");
  end

  localparam logic [31:0]         TAP_FULL = lfsr_tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] lfsr_q;
  logic [NUM_BITS-1:0] lfsr_d;
  logic [NUM_BITS-1:0] shift_val;
  logic                fb;

  always_comb begin
    fb        = ~^(lfsr_q & TAP_MASK);
    shift_val = {lfsr_q[NUM_BITS-2:0], fb};
`ifdef LFSR_LOCKUP_GUARD_EN
    if (&lfsr_q) begin
      shift_val = '0;
    end
`endif
    // Seed load wins over shifting regardless of enable.
    lfsr_d = lfsr_q;
    if (i_Seed_DV) begin
      lfsr_d = i_Seed_Data;
    end else if (i_Enable) begin
      lfsr_d = shift_val;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_LFSR_Data = lfsr_q;
  assign o_LFSR_Done = (lfsr_q == i_Seed_Data);

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - directed scoreboard bench for lfsr plus period sweep over widths 3..16
module tb_lfsr;

  localparam int NP = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dv = 1'b0;
  logic [2:0] seed = 3'b000;
  logic [2:0] data;
  logic       done;

  logic       p_rst = 1'b1;
  logic       p_en = 1'b0;
  logic       p_en_q = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [2:0] model_q = 3'b000;
  logic [2:0] exp_q[$];

  wire [31:0] cnt_arr [0:NP-1];
  wire [NP-1:0] fin_vec;
  wire [NP-1:0] rep_vec;

  always #5 clk = ~clk;
  always @(posedge clk) p_en_q <= p_en;

  lfsr #(.NUM_BITS(3)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Enable    (en),
    .i_Seed_DV   (dv),
    .i_Seed_Data (seed),
    .o_LFSR_Data (data),
    .o_LFSR_Done (done)
  );

  for (genvar g = 0; g < NP; g++) begin : g_per
    localparam int N = g + 3;
    logic [N-1:0] d;
    logic         dn;
    bit           seen [0:(1<<N)-1];
    int           cnt = 0;
    bit           fin = 1'b0;
    bit           rep = 1'b0;

    lfsr #(.NUM_BITS(N)) u_per (
      .i_Clk       (clk),
      .i_Rst       (p_rst),
      .i_Enable    (p_en),
      .i_Seed_DV   (1'b0),
      .i_Seed_Data ({N{1'b0}}),
      .o_LFSR_Data (d),
      .o_LFSR_Done (dn)
    );

    always @(negedge clk) begin
      if (p_en_q && !fin) begin
        cnt = cnt + 1;
        if (d == '0) begin
          fin = 1'b1;
        end else begin
          if (seen[d]) rep = 1'b1;
          seen[d] = 1'b1;
        end
      end
    end

    assign cnt_arr[g] = cnt;
    assign fin_vec[g] = fin;
    assign rep_vec[g] = rep;
  end

  // Reference successor table for the 3-bit register, taken from the expected sequence.
  function automatic logic [2:0] succ3(input logic [2:0] s);
    case (s)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b110;
      3'b110:  return 3'b101;
      3'b101:  return 3'b010;
      3'b010:  return 3'b100;
      3'b100:  return 3'b000;
`ifdef LFSR_LOCKUP_GUARD_EN
      default: return 3'b000;
`else
      default: return 3'b111;
`endif
    endcase
  endfunction

  task automatic step(input logic r, input logic l, input logic [2:0] sd, input logic e,
                      input string tag);
    logic [2:0] exp_d;
    logic       exp_done;
    @(negedge clk);
    rst = r;
    dv = l;
    seed = sd;
    en = e;
    if (r) model_q = 3'b000;
    else if (l) model_q = sd;
    else if (e) model_q = succ3(model_q);
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    exp_d = exp_q.pop_front();
    exp_done = (exp_d == sd);
    checks++;
    assert (data === exp_d) else begin
      failures++;
      $error("FAIL %s data observed=%b expected=%b", tag, data, exp_d);
    end
    checks++;
    assert (done === exp_done) else begin
      failures++;
      $error("FAIL %s done observed=%b expected=%b", tag, done, exp_done);
    end
  endtask

  initial begin
    int budget;

    step(1'b1, 1'b0, 3'b000, 1'b0, "reset_seed0");
    step(1'b1, 1'b1, 3'b101, 1'b1, "reset_ignores_dv_en");
    p_rst = 1'b0;

    step(1'b0, 1'b1, 3'b000, 1'b0, "load_seed0");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'b000, 1'b1, "seq_seed0");

    step(1'b0, 1'b1, 3'b101, 1'b0, "load_101");
    step(1'b0, 1'b0, 3'b101, 1'b0, "hold_101_a");
    step(1'b0, 1'b0, 3'b101, 1'b0, "hold_101_b");
    step(1'b0, 1'b0, 3'b101, 1'b1, "shift_from_101");
    step(1'b0, 1'b0, 3'b101, 1'b1, "shift_mid");
    step(1'b0, 1'b1, 3'b011, 1'b1, "load_beats_enable");
    step(1'b0, 1'b0, 3'b011, 1'b1, "shift_after_load");
    step(1'b1, 1'b1, 3'b110, 1'b1, "mid_reset_priority");
    step(1'b0, 1'b0, 3'b110, 1'b1, "shift_after_reset");

    step(1'b0, 1'b1, 3'b111, 1'b0, "load_111");
    step(1'b0, 1'b0, 3'b111, 1'b1, "lockup_shift_1");
    step(1'b0, 1'b0, 3'b111, 1'b1, "lockup_shift_2");
    step(1'b0, 1'b0, 3'b111, 1'b1, "lockup_shift_3");

    @(negedge clk);
    p_en = 1'b1;
    budget = 0;
    while (!(&fin_vec) && budget < 70000) begin
      @(negedge clk);
      budget++;
    end
    p_en = 1'b0;
    checks++;
    assert (&fin_vec === 1'b1) else begin
      failures++;
      $error("FAIL period_timeout finished=%b expected=%b", fin_vec, {NP{1'b1}});
    end
    for (int g = 0; g < NP; g++) begin
      checks++;
      assert (cnt_arr[g] === (32'd1 << (g + 3)) - 32'd1) else begin
        failures++;
        $error("FAIL period_n%0d observed=%0d expected=%0d", g + 3, cnt_arr[g],
               (32'd1 << (g + 3)) - 32'd1);
      end
      checks++;
      assert (rep_vec[g] === 1'b0) else begin
        failures++;
        $error("FAIL repeat_n%0d observed=%b expected=0", g + 3, rep_vec[g]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
